// File: rtl/result_drain_streamer.sv
// result_drain_streamer
// Reads NUM_ROWS rows of MATRIX_SIZE partial sums from the results SRAM,
// starting at base_addr. Each row is sent as MATRIX_SIZE/LANES beats of LANES
// sums on a valid/ready stream. The sums are signed, but they pass through
// unchanged, so the datapath treats them as raw bits.
// Build option DRAIN_PREFETCH_EN adds a second row register. The next row is
// then read while the current one streams, so rows follow with no bubble.
// Without it, two idle cycles (read, wait) separate consecutive rows.
// With the prefetch build, a row must span at least 3 beats
// (MATRIX_SIZE/LANES >= 3). The prefetched data then lands before the row
// boundary is reached.
module result_drain_streamer #(
   parameter int ADDRESSSIZE    = 10,
   parameter int MATRIX_SIZE    = 64,
   parameter int PARTIAL_SUM_BW = 24,
   parameter int LANES          = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [ADDRESSSIZE-1:0]                base_addr,
   input  logic [ADDRESSSIZE-1:0]                num_rows,
   output logic                                  sram_re,
   output logic [ADDRESSSIZE-1:0]                sram_addr,
   input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] sram_rdata,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic [LANES*PARTIAL_SUM_BW-1:0]       m_data,
   output logic                                  m_last,
   output logic                                  busy,
   output logic                                  done
);
   localparam int BEATS   = MATRIX_SIZE / LANES;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROW_W   = MATRIX_SIZE * PARTIAL_SUM_BW;
   localparam int BEAT_DW = LANES * PARTIAL_SUM_BW;
   localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [ADDRESSSIZE-1:0] ONE       = ADDRESSSIZE'(1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_ST, S_DONE} state_t;

   state_t                 state_q;
   logic [ADDRESSSIZE-1:0] base_q, num_q, row_cnt_q, sram_addr_q;
   logic [BEAT_W-1:0]      beat_cnt_q;
   logic                   sram_re_q, m_valid_q, busy_q, done_q;
   logic [ROW_W-1:0]       row_q;
   logic [BEAT_DW-1:0]     m_data_d;
   logic                   xfer_d, last_beat_d, last_row_d;
   logic [ADDRESSSIZE-1:0] row_nxt_d;
`ifdef DRAIN_PREFETCH_EN
   logic [ROW_W-1:0]       nxt_row_q;
   logic                   pf_cap_q;
   logic                   nxt_last_d;
`endif

   assign xfer_d      = m_valid_q & m_ready;
   assign last_beat_d = (beat_cnt_q == LAST_BEAT);
   assign last_row_d  = (row_cnt_q == num_q - ONE);
   assign row_nxt_d   = row_cnt_q + ONE;
`ifdef DRAIN_PREFETCH_EN
   assign nxt_last_d  = (row_nxt_d == num_q - ONE);
`endif

   // Control FSM: sequences SRAM reads and beat streaming, and owns every registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         num_q       <= '0;
         row_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         sram_re_q   <= 1'b0;
         sram_addr_q <= '0;
         m_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef DRAIN_PREFETCH_EN
         pf_cap_q    <= 1'b0;
`endif
      end else begin
         sram_re_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef DRAIN_PREFETCH_EN
         // A read issued while streaming returns data one cycle later.
         pf_cap_q  <= (state_q == S_ST) & sram_re_q;
`endif
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q     <= base_addr;
                  num_q      <= num_rows;
                  row_cnt_q  <= '0;
                  beat_cnt_q <= '0;
                  if (num_rows != '0) begin
                     state_q     <= S_RD;
                     busy_q      <= 1'b1;
                     sram_re_q   <= 1'b1;
                     sram_addr_q <= base_addr;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_RD: state_q <= S_WT;
            S_WT: begin
               state_q   <= S_ST;
               m_valid_q <= 1'b1;
`ifdef DRAIN_PREFETCH_EN
               if (!last_row_d) begin
                  sram_re_q   <= 1'b1;
                  sram_addr_q <= base_q + row_nxt_d;
               end
`endif
            end
            S_ST: begin
               if (xfer_d) begin
                  if (last_beat_d) begin
                     beat_cnt_q <= '0;
                     if (last_row_d) begin
                        state_q   <= S_DONE;
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                     end else begin
                        row_cnt_q <= row_nxt_d;
`ifdef DRAIN_PREFETCH_EN
                        // The next row is already buffered; fetch the one after it.
                        if (!nxt_last_d) begin
                           sram_re_q   <= 1'b1;
                           sram_addr_q <= base_q + row_nxt_d + ONE;
                        end
`else
                        state_q     <= S_RD;
                        m_valid_q   <= 1'b0;
                        sram_re_q   <= 1'b1;
                        sram_addr_q <= base_q + row_nxt_d;
`endif
                     end
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Row storage: capture SRAM data in the cycle it is valid (no reset, data only).
   always_ff @(posedge clk) begin
      if (state_q == S_WT) begin
         row_q <= sram_rdata;
      end
`ifdef DRAIN_PREFETCH_EN
      else if (state_q == S_ST && xfer_d && last_beat_d && !last_row_d) begin
         row_q <= nxt_row_q;
      end
      if (pf_cap_q) begin
         nxt_row_q <= sram_rdata;
      end
`endif
   end

   // Beat select: the current slice of the row; driven to zero while no beat is offered.
   always_comb begin
      m_data_d = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (m_valid_q && beat_cnt_q == BEAT_W'(b)) begin
            m_data_d = row_q[b*BEAT_DW +: BEAT_DW];
         end
      end
   end

   assign sram_re   = sram_re_q;
   assign sram_addr = sram_addr_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_d;
   assign m_last    = m_valid_q & last_beat_d & last_row_d;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
